network_descriptor_buffer: RTL and testbench
============================================

Name: network_descriptor_buffer

Overview:
- Per-port descriptor buffer sitting directly upstream of the network transmit port.
- Accepts single-cycle descriptors ({tsntag, bufid}) from the forwarding/lookup stage and classifies them into a high-priority queue (TS/RC) and a low-priority queue (BE).
- Presents them to the port's network descriptor interface with strict priority under a wr/ack handshake.
- Descriptors that cannot be queued are dropped and their bufid is returned to the packet centralized buffer (PCB) for release.

Parameters:
HI_DEPTH, 16, entries in high-priority descriptor FIFO (power of 2)
LO_DEPTH, 32, entries in low-priority descriptor FIFO (power of 2)
REL_DEPTH, 4, entries in drop-release FIFO (power of 2)

Ports:
i_clk  in  1  core clock
i_rst_n  in  1  asynchronous active-low reset
iv_cfg_finish  in  2  configuration state; 2'b00 = not configured
iv_tsntag  in  48  tsntag from lookup; [47:45] = flow type
iv_bufid  in  9  packet buffer id
i_descriptor_wr  in  1  one-cycle descriptor valid; no backpressure
ov_tsntag_network  out  48  descriptor tsntag to transmit port
ov_bufid_network  out  9  descriptor bufid to transmit port
o_descriptor_wr_network  out  1  descriptor valid, held until ack
i_descriptor_ack_network  in  1  one-cycle accept from transmit port
ov_pkt_bufid  out  9  bufid to PCB for release
o_pkt_bufid_wr  out  1  release request, held until ack
i_pkt_bufid_ack  in  1  one-cycle release accept
o_fifo_overflow_pulse  out  1  one-cycle pulse per dropped descriptor
o_release_lost_pulse  out  1  one-cycle pulse when a drop could not be queued for release
ov_hi_count  out  5  high-queue occupancy
ov_lo_count  out  6  low-queue occupancy
dbs_state  out  2  output FSM state (debug)

Behaviour:
- Reset: all outputs 0; FIFOs empty; FSM IDLE. Reset mid-handshake abandons the pending descriptor and release without side effects.
- Classification: flow type [47:45] values 0–4 go to the HI queue; values 5–7 go to the LO queue.
- Enqueue: on i_descriptor_wr, the descriptor is written the same cycle if the target FIFO is not full.
- Drop conditions: the target FIFO is full, or iv_cfg_finish == 2'b00. On drop:
  - o_fifo_overflow_pulse is asserted the next cycle.
  - bufid is pushed into the release FIFO.
  - If the release FIFO is also full, o_release_lost_pulse is asserted the next cycle and the bufid is discarded.
- Output FSM (dbs_state):
  - IDLE (0): if HI is non-empty, pop HI; else if LO is non-empty, pop LO. Load the output registers and go to SEND. Strict priority, no aging.
  - SEND (1): o_descriptor_wr_network = 1 with stable data. On i_descriptor_ack_network, deassert wr next cycle and go to GAP.
  - GAP (2): one cycle with wr = 0, then IDLE.
  - Result: minimum 3 cycles per descriptor. Latency from enqueue into an empty buffer to wr asserted = 2 cycles.
- Release FSM (independent):
  - When the release FIFO is non-empty and o_pkt_bufid_wr = 0, pop it and assert o_pkt_bufid_wr with ov_pkt_bufid.
  - Hold until i_pkt_bufid_ack, then deassert for at least one cycle.
- Simultaneous events:
  - Enqueue and pop on the same FIFO in the same cycle are both performed.
  - A full FIFO popped in the same cycle still drops the incoming descriptor. Full is evaluated before the pop.
  - An ack arriving while wr = 0 is ignored.
- Counters: occupancy counts are exact, saturate at DEPTH, and never wrap. Pointers wrap modulo DEPTH.
- cfg change: dropping iv_cfg_finish to 0 does not flush queued descriptors; it only blocks new enqueues.

Decomposition:
- Shared package: flow-type constants (TS/RC/BE encodings, HI/LO split threshold 3'd5), FSM state encodings, descriptor width constant (57).
- Sub-module descriptor_sync_fifo: parameterized WIDTH/DEPTH, show-ahead, with full/empty/count outputs. Instantiated for HI (57b), LO (57b) and release (9b).

Test Plan:
- Single descriptor: reset, cfg=2'b11, enqueue type 0, bufid 9'h05 -> wr high 2 cycles later with bufid 5. Ack -> wr low next cycle. ov_hi_count returns to 0.
- Strict priority: with ack held off, enqueue BE bufid 1 then TS bufid 2, 3 -> first grant is bufid 1 (already loaded); next grants are 2, then 3, then BE queue.
- Overflow: fill HI with 16 descriptors, ack withheld, then enqueue a 17th HI, bufid 9'h1AA -> o_fifo_overflow_pulse for 1 cycle; o_pkt_bufid_wr with 9'h1AA. ov_hi_count stays 16.
- Unconfigured: cfg=2'b00, enqueue bufid 7 -> dropped and released; output wr never asserts.
- Release loss: i_pkt_bufid_ack held 0; cause 6 drops -> 1 in the release register and 4 in the FIFO; 6th drop gives o_release_lost_pulse; then ack 5 times releases all 5 in order.
- Reset mid-SEND: assert i_rst_n=0 while wr is high -> all outputs 0 and counts 0; no descriptor is emitted after reset.

Source files
------------

// File: rtl/network_descriptor_buffer_pkg.sv
// Shared widths, flow classification and output FSM encoding
// for the per-port network descriptor buffer.
package network_descriptor_buffer_pkg;

  localparam int TSNTAG_W = 48;
  localparam int BUFID_W  = 9;
  localparam int DESC_W   = TSNTAG_W + BUFID_W;

  // Flow types below the split (TS/RC) are high priority; the rest are BE.
  localparam logic [2:0] FLOW_HI_LO_SPLIT = 3'd5;
  localparam logic [2:0] FLOW_BE_MIN      = FLOW_HI_LO_SPLIT;

  typedef enum logic [1:0] {
    DBS_IDLE = 2'd0,
    DBS_SEND = 2'd1,
    DBS_GAP  = 2'd2
  } dbs_state_e;

  function automatic logic is_hi_flow(input logic [2:0] flowType);
    return flowType < FLOW_HI_LO_SPLIT;
  endfunction

endpackage

// File: rtl/network_descriptor_buffer_sync_fifo.sv
// Show-ahead synchronous FIFO with exact occupancy count.
// A push into a full FIFO is refused even if a pop happens in the same cycle.
module descriptor_sync_fifo #(
  parameter int WIDTH = 57,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wrPtr_q, rdPtr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             pushOk, popOk;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign pushOk  = push_i && !full_o;
  assign popOk   = pop_i && !empty_o;
  assign data_o  = mem_q[rdPtr_q];
  assign count_o = count_q;

  always_comb begin
    count_d = count_q;
    if (pushOk && !popOk) begin
      count_d = count_q + CW'(1);
    end else if (popOk && !pushOk) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (pushOk) wrPtr_q <= wrPtr_q + AW'(1);
      if (popOk)  rdPtr_q <= rdPtr_q + AW'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (pushOk) mem_q[wrPtr_q] <= data_i;
  end

endmodule

// File: rtl/network_descriptor_buffer.sv
// Per-port descriptor buffer: classifies descriptors into HI/LO queues, serves them
// with strict priority over a wr/ack handshake, and returns dropped bufids to the PCB.
module network_descriptor_buffer
  import network_descriptor_buffer_pkg::*;
#(
  parameter int HI_DEPTH  = 16,
  parameter int LO_DEPTH  = 32,
  parameter int REL_DEPTH = 4
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic [1:0]                  iv_cfg_finish,
  input  logic [TSNTAG_W-1:0]         iv_tsntag,
  input  logic [BUFID_W-1:0]          iv_bufid,
  input  logic                        i_descriptor_wr,
  output logic [TSNTAG_W-1:0]         ov_tsntag_network,
  output logic [BUFID_W-1:0]          ov_bufid_network,
  output logic                        o_descriptor_wr_network,
  input  logic                        i_descriptor_ack_network,
  output logic [BUFID_W-1:0]          ov_pkt_bufid,
  output logic                        o_pkt_bufid_wr,
  input  logic                        i_pkt_bufid_ack,
  output logic                        o_fifo_overflow_pulse,
  output logic                        o_release_lost_pulse,
  output logic [$clog2(HI_DEPTH):0]   ov_hi_count,
  output logic [$clog2(LO_DEPTH):0]   ov_lo_count,
  output logic [1:0]                  dbs_state
);

  logic                      isHi, cfgOk, drop;
  logic                      hiPush, loPush, hiPop, loPop, relPop;
  logic                      hiFull, hiEmpty, loFull, loEmpty, relFull, relEmpty;
  logic [DESC_W-1:0]         inDesc, hiData, loData, popData;
  logic [BUFID_W-1:0]        relData;
  logic [$clog2(REL_DEPTH):0] relCount_unused;

  dbs_state_e                state_q;
  logic                      descWr_q, relWr_q, overflow_q, relLost_q;
  logic [TSNTAG_W-1:0]       outTsntag_q;
  logic [BUFID_W-1:0]        outBufid_q, relBufid_q;

  assign isHi   = is_hi_flow(iv_tsntag[47:45]);
  assign cfgOk  = (iv_cfg_finish != 2'b00);
  assign inDesc = {iv_tsntag, iv_bufid};
  assign hiPush = i_descriptor_wr && cfgOk && isHi && !hiFull;
  assign loPush = i_descriptor_wr && cfgOk && !isHi && !loFull;
  assign drop   = i_descriptor_wr && (!cfgOk || (isHi ? hiFull : loFull));

  assign hiPop   = (state_q == DBS_IDLE) && !hiEmpty;
  assign loPop   = (state_q == DBS_IDLE) && hiEmpty && !loEmpty;
  assign popData = hiEmpty ? loData : hiData;
  assign relPop  = !relWr_q && !relEmpty;

  descriptor_sync_fifo #(.WIDTH(DESC_W), .DEPTH(HI_DEPTH)) uHiFifo (
    .clk_i(i_clk), .rst_ni(i_rst_n), .push_i(hiPush), .data_i(inDesc), .pop_i(hiPop),
    .data_o(hiData), .full_o(hiFull), .empty_o(hiEmpty), .count_o(ov_hi_count)
  );

  descriptor_sync_fifo #(.WIDTH(DESC_W), .DEPTH(LO_DEPTH)) uLoFifo (
    .clk_i(i_clk), .rst_ni(i_rst_n), .push_i(loPush), .data_i(inDesc), .pop_i(loPop),
    .data_o(loData), .full_o(loFull), .empty_o(loEmpty), .count_o(ov_lo_count)
  );

  descriptor_sync_fifo #(.WIDTH(BUFID_W), .DEPTH(REL_DEPTH)) uRelFifo (
    .clk_i(i_clk), .rst_ni(i_rst_n), .push_i(drop), .data_i(iv_bufid), .pop_i(relPop),
    .data_o(relData), .full_o(relFull), .empty_o(relEmpty), .count_o(relCount_unused)
  );

  // Output FSM: IDLE loads a descriptor, SEND holds it until ack, GAP idles one cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= DBS_IDLE;
      descWr_q    <= 1'b0;
      outTsntag_q <= '0;
      outBufid_q  <= '0;
    end else begin
      case (state_q)
        DBS_IDLE: begin
          if (!hiEmpty || !loEmpty) begin
            outTsntag_q <= popData[DESC_W-1:BUFID_W];
            outBufid_q  <= popData[BUFID_W-1:0];
            descWr_q    <= 1'b1;
            state_q     <= DBS_SEND;
          end
        end
        DBS_SEND: begin
          if (i_descriptor_ack_network) begin
            descWr_q <= 1'b0;
            state_q  <= DBS_GAP;
          end
        end
        DBS_GAP:  state_q <= DBS_IDLE;
        default:  state_q <= DBS_IDLE;
      endcase
    end
  end

  // Release request holds until acked; the idle cycle after ack guarantees a gap.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      relWr_q    <= 1'b0;
      relBufid_q <= '0;
      overflow_q <= 1'b0;
      relLost_q  <= 1'b0;
    end else begin
      overflow_q <= drop;
      relLost_q  <= drop && relFull;
      if (relWr_q) begin
        if (i_pkt_bufid_ack) relWr_q <= 1'b0;
      end else if (!relEmpty) begin
        relWr_q    <= 1'b1;
        relBufid_q <= relData;
      end
    end
  end

  assign ov_tsntag_network       = outTsntag_q;
  assign ov_bufid_network        = outBufid_q;
  assign o_descriptor_wr_network = descWr_q;
  assign ov_pkt_bufid            = relBufid_q;
  assign o_pkt_bufid_wr          = relWr_q;
  assign o_fifo_overflow_pulse   = overflow_q;
  assign o_release_lost_pulse    = relLost_q;
  assign dbs_state               = state_q;

endmodule

// File: tb/tb_network_descriptor_buffer.sv
// Directed bench for network_descriptor_buffer: classification table plus
// hand-written priority, overflow, release-loss and reset sequences.
module tb_network_descriptor_buffer;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic [1:0]  iv_cfg_finish = 2'b00;
  logic [47:0] iv_tsntag = '0;
  logic [8:0]  iv_bufid = '0;
  logic        i_descriptor_wr = 1'b0;
  logic [47:0] ov_tsntag_network;
  logic [8:0]  ov_bufid_network;
  logic        o_descriptor_wr_network;
  logic        i_descriptor_ack_network = 1'b0;
  logic [8:0]  ov_pkt_bufid;
  logic        o_pkt_bufid_wr;
  logic        i_pkt_bufid_ack = 1'b0;
  logic        o_fifo_overflow_pulse;
  logic        o_release_lost_pulse;
  logic [4:0]  ov_hi_count;
  logic [5:0]  ov_lo_count;
  logic [1:0]  dbs_state;

  int total = 0;
  int bad = 0;

  typedef struct packed {
    logic [1:0] cfg;
    logic [2:0] ftype;
    logic [8:0] bufid;
    logic [4:0] expHi;
    logic [5:0] expLo;
    logic       expDrop;
  } vec_t;

  vec_t vecs [10];

  network_descriptor_buffer dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .iv_cfg_finish(iv_cfg_finish),
    .iv_tsntag(iv_tsntag), .iv_bufid(iv_bufid), .i_descriptor_wr(i_descriptor_wr),
    .ov_tsntag_network(ov_tsntag_network), .ov_bufid_network(ov_bufid_network),
    .o_descriptor_wr_network(o_descriptor_wr_network),
    .i_descriptor_ack_network(i_descriptor_ack_network),
    .ov_pkt_bufid(ov_pkt_bufid), .o_pkt_bufid_wr(o_pkt_bufid_wr),
    .i_pkt_bufid_ack(i_pkt_bufid_ack), .o_fifo_overflow_pulse(o_fifo_overflow_pulse),
    .o_release_lost_pulse(o_release_lost_pulse), .ov_hi_count(ov_hi_count),
    .ov_lo_count(ov_lo_count), .dbs_state(dbs_state)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [47:0] makeTag(input logic [2:0] ftype, input logic [8:0] bufid);
    return {ftype, 36'h5A5A5A5A5, bufid};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", name, actual, expected);
    end
  endtask

  // Drive one descriptor for exactly one cycle; returns at the following negedge.
  task automatic applyStimulus(input logic [1:0] cfg, input logic [2:0] ftype, input logic [8:0] bufid);
    iv_cfg_finish   = cfg;
    iv_tsntag       = makeTag(ftype, bufid);
    iv_bufid        = bufid;
    i_descriptor_wr = 1'b1;
    @(negedge i_clk);
    i_descriptor_wr = 1'b0;
  endtask

  task automatic waitGrant(input logic [8:0] expBufid);
    int n = 0;
    while (!o_descriptor_wr_network && n < 50) begin
      @(negedge i_clk);
      n++;
    end
    checkOutput("grant wr", 64'(o_descriptor_wr_network), 64'd1);
    checkOutput("grant bufid", 64'(ov_bufid_network), 64'(expBufid));
    i_descriptor_ack_network = 1'b1;
    @(negedge i_clk);
    i_descriptor_ack_network = 1'b0;
    checkOutput("grant wr after ack", 64'(o_descriptor_wr_network), 64'd0);
  endtask

  task automatic waitRelease(input logic [8:0] expBufid);
    int n = 0;
    while (!o_pkt_bufid_wr && n < 50) begin
      @(negedge i_clk);
      n++;
    end
    checkOutput("release wr", 64'(o_pkt_bufid_wr), 64'd1);
    checkOutput("release bufid", 64'(ov_pkt_bufid), 64'(expBufid));
    i_pkt_bufid_ack = 1'b1;
    @(negedge i_clk);
    i_pkt_bufid_ack = 1'b0;
    checkOutput("release wr after ack", 64'(o_pkt_bufid_wr), 64'd0);
  endtask

  initial begin
    vecs[0] = '{2'd3, 3'd0, 9'h005, 5'd1, 6'd0, 1'b0};
    vecs[1] = '{2'd3, 3'd1, 9'h010, 5'd1, 6'd0, 1'b0};
    vecs[2] = '{2'd1, 3'd2, 9'h011, 5'd1, 6'd0, 1'b0};
    vecs[3] = '{2'd2, 3'd3, 9'h012, 5'd1, 6'd0, 1'b0};
    vecs[4] = '{2'd3, 3'd4, 9'h013, 5'd1, 6'd0, 1'b0};
    vecs[5] = '{2'd3, 3'd5, 9'h014, 5'd0, 6'd1, 1'b0};
    vecs[6] = '{2'd3, 3'd6, 9'h015, 5'd0, 6'd1, 1'b0};
    vecs[7] = '{2'd3, 3'd7, 9'h1FF, 5'd0, 6'd1, 1'b0};
    vecs[8] = '{2'd0, 3'd0, 9'h007, 5'd0, 6'd0, 1'b1};
    vecs[9] = '{2'd0, 3'd6, 9'h0C3, 5'd0, 6'd0, 1'b1};

    repeat (2) @(negedge i_clk);
    checkOutput("reset wr", 64'(o_descriptor_wr_network), 64'd0);
    checkOutput("reset pkt wr", 64'(o_pkt_bufid_wr), 64'd0);
    checkOutput("reset hi count", 64'(ov_hi_count), 64'd0);
    checkOutput("reset lo count", 64'(ov_lo_count), 64'd0);
    checkOutput("reset state", 64'(dbs_state), 64'd0);
    i_rst_n = 1'b1;
    @(negedge i_clk);

    // Classification table: one descriptor at a time into an idle buffer.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].cfg, vecs[i].ftype, vecs[i].bufid);
      checkOutput("vec hi count", 64'(ov_hi_count), 64'(vecs[i].expHi));
      checkOutput("vec lo count", 64'(ov_lo_count), 64'(vecs[i].expLo));
      checkOutput("vec overflow", 64'(o_fifo_overflow_pulse), 64'(vecs[i].expDrop));
      @(negedge i_clk);
      checkOutput("vec overflow one cycle", 64'(o_fifo_overflow_pulse), 64'd0);
      if (!vecs[i].expDrop) begin
        checkOutput("vec wr", 64'(o_descriptor_wr_network), 64'd1);
        checkOutput("vec state send", 64'(dbs_state), 64'd1);
        checkOutput("vec tsntag", 64'(ov_tsntag_network), 64'(makeTag(vecs[i].ftype, vecs[i].bufid)));
        checkOutput("vec bufid", 64'(ov_bufid_network), 64'(vecs[i].bufid));
        checkOutput("vec counts drained", 64'({ov_hi_count, ov_lo_count}), 64'd0);
        i_descriptor_ack_network = 1'b1;
        @(negedge i_clk);
        i_descriptor_ack_network = 1'b0;
        checkOutput("vec wr after ack", 64'(o_descriptor_wr_network), 64'd0);
        checkOutput("vec state gap", 64'(dbs_state), 64'd2);
        @(negedge i_clk);
      end else begin
        checkOutput("vec drop no wr", 64'(o_descriptor_wr_network), 64'd0);
        waitRelease(vecs[i].bufid);
        @(negedge i_clk);
        checkOutput("vec drop still no wr", 64'(o_descriptor_wr_network), 64'd0);
      end
    end

    // Strict priority: BE is loaded first, then TS entries win over the next BE.
    applyStimulus(2'd3, 3'd6, 9'h001);
    applyStimulus(2'd3, 3'd0, 9'h002);
    applyStimulus(2'd3, 3'd1, 9'h003);
    applyStimulus(2'd3, 3'd7, 9'h004);
    checkOutput("prio hi count", 64'(ov_hi_count), 64'd2);
    checkOutput("prio lo count", 64'(ov_lo_count), 64'd1);
    repeat (3) @(negedge i_clk);
    waitGrant(9'h001);
    waitGrant(9'h002);
    waitGrant(9'h003);
    waitGrant(9'h004);

    // Overflow: one entry sits in SEND, so 17 pushes fill HI to 16.
    for (int k = 0; k < 17; k++) applyStimulus(2'd3, 3'd0, 9'(9'h020 + k));
    checkOutput("ovf hi full", 64'(ov_hi_count), 64'd16);
    checkOutput("ovf held bufid", 64'(ov_bufid_network), 64'h020);
    applyStimulus(2'd3, 3'd1, 9'h1AA);
    checkOutput("ovf pulse", 64'(o_fifo_overflow_pulse), 64'd1);
    checkOutput("ovf hi stays", 64'(ov_hi_count), 64'd16);
    @(negedge i_clk);
    checkOutput("ovf pulse width", 64'(o_fifo_overflow_pulse), 64'd0);
    waitRelease(9'h1AA);
    i_descriptor_ack_network = 1'b1;
    @(negedge i_clk);
    i_descriptor_ack_network = 1'b0;
    @(negedge i_clk);
    // Push lands on the same edge as the IDLE pop of a full queue: still dropped.
    applyStimulus(2'd3, 3'd2, 9'h1BB);
    checkOutput("full+pop drop", 64'(o_fifo_overflow_pulse), 64'd1);
    checkOutput("full+pop count", 64'(ov_hi_count), 64'd15);
    checkOutput("full+pop bufid", 64'(ov_bufid_network), 64'h021);
    waitRelease(9'h1BB);
    for (int k = 1; k < 17; k++) waitGrant(9'(9'h020 + k));
    checkOutput("ovf drained", 64'(ov_hi_count), 64'd0);

    // Release loss: ack withheld, six back-to-back unconfigured drops.
    for (int k = 0; k < 6; k++) begin
      applyStimulus(2'd0, 3'd0, 9'(9'h040 + k));
      checkOutput("loss overflow", 64'(o_fifo_overflow_pulse), 64'd1);
      checkOutput("loss pulse", 64'(o_release_lost_pulse), 64'(k == 5));
    end
    @(negedge i_clk);
    checkOutput("loss pulse width", 64'(o_release_lost_pulse), 64'd0);
    for (int k = 0; k < 5; k++) waitRelease(9'(9'h040 + k));
    repeat (3) @(negedge i_clk);
    checkOutput("loss all released", 64'(o_pkt_bufid_wr), 64'd0);
    checkOutput("loss no desc wr", 64'(o_descriptor_wr_network), 64'd0);

    // Ack while wr is low is ignored, then reset in the middle of SEND.
    i_descriptor_ack_network = 1'b1;
    applyStimulus(2'd3, 3'd0, 9'h077);
    iv_bufid = 9'h078;
    iv_tsntag = makeTag(3'd1, 9'h078);
    i_descriptor_wr = 1'b1;
    @(negedge i_clk);
    i_descriptor_wr = 1'b0;
    i_descriptor_ack_network = 1'b0;
    @(negedge i_clk);
    checkOutput("stray ack wr", 64'(o_descriptor_wr_network), 64'd1);
    checkOutput("stray ack bufid", 64'(ov_bufid_network), 64'h077);
    checkOutput("pre-reset hi", 64'(ov_hi_count), 64'd1);
    i_rst_n = 1'b0;
    #1;
    checkOutput("mid reset wr", 64'(o_descriptor_wr_network), 64'd0);
    checkOutput("mid reset bufid", 64'(ov_bufid_network), 64'd0);
    checkOutput("mid reset tsntag", 64'(ov_tsntag_network), 64'd0);
    checkOutput("mid reset hi", 64'(ov_hi_count), 64'd0);
    checkOutput("mid reset state", 64'(dbs_state), 64'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge i_clk);
      checkOutput("post reset quiet", 64'({o_descriptor_wr_network, o_pkt_bufid_wr}), 64'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
